// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encoding, register index width and the
// bubble value loaded by flushed pipeline registers.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // Every pipeline register clears to this value on flush.
    localparam logic BUBBLE = 1'b0;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_detect.sv
// Combinational RAW compare of one ID source register against one downstream stage.
module pipeline_hazard_ctrl_raw_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             src_used,
    input  logic [REG_W-1:0] dest,
    input  logic             wb_en,
    output logic             hit
);

    // Register 0 is hard-wired, so it never carries a dependency.
    assign hit = src_used && wb_en && (src != '0) && (src == dest);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with saturating stall and
// flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W = pipeline_hazard_ctrl_pkg::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1_id,
    input  logic [REG_W-1:0] src2_id,
    input  logic             two_src_id,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             if2id_hold,
    output logic             id2exe_hold,
    output logic             exe2mem_hold,
    output logic             if2id_flush,
    output logic             id2exe_flush,
    output logic             mem2wb_flush,
    output logic             state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    import pipeline_hazard_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic hit1_exe, hit2_exe, hit1_mem, hit2_mem;
    logic data_hazard, mem_wait;

    pipeline_hazard_ctrl_raw_detect #(.REG_W(REG_W)) u_raw_s1_exe (
        .src(src1_id), .src_used(1'b1), .dest(exe_dest), .wb_en(exe_wb_en), .hit(hit1_exe)
    );
    pipeline_hazard_ctrl_raw_detect #(.REG_W(REG_W)) u_raw_s2_exe (
        .src(src2_id), .src_used(two_src_id), .dest(exe_dest), .wb_en(exe_wb_en),
        .hit(hit2_exe)
    );
    pipeline_hazard_ctrl_raw_detect #(.REG_W(REG_W)) u_raw_s1_mem (
        .src(src1_id), .src_used(1'b1), .dest(mem_dest), .wb_en(mem_wb_en), .hit(hit1_mem)
    );
    pipeline_hazard_ctrl_raw_detect #(.REG_W(REG_W)) u_raw_s2_mem (
        .src(src2_id), .src_used(two_src_id), .dest(mem_dest), .wb_en(mem_wb_en),
        .hit(hit2_mem)
    );

    always_comb begin
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (fwd_en) begin
            data_hazard = exe_mem_r_en && (hit1_exe || hit2_exe);
        end else begin
            data_hazard = hit1_exe || hit2_exe || hit1_mem || hit2_mem;
        end

        mem_wait = (state_q == ST_RUN) ? (mem_req && !mem_ready) : !mem_ready;
        state_d  = mem_wait ? ST_MEM_WAIT : ST_RUN;

        pc_hold      = 1'b0;
        if2id_hold   = 1'b0;
        id2exe_hold  = 1'b0;
        exe2mem_hold = 1'b0;
        if2id_flush  = 1'b0;
        id2exe_flush = 1'b0;
        mem2wb_flush = 1'b0;

        // Outputs are forced low while reset is asserted, regardless of inputs.
        if (rst) begin
            state_d = ST_RUN;
        end else if (mem_wait) begin
            pc_hold      = 1'b1;
            if2id_hold   = 1'b1;
            id2exe_hold  = 1'b1;
            exe2mem_hold = 1'b1;
            mem2wb_flush = 1'b1;
        end else if (br_taken) begin
            if2id_flush  = 1'b1;
            id2exe_flush = 1'b1;
        end else if (data_hazard) begin
            pc_hold      = 1'b1;
            if2id_hold   = 1'b1;
            id2exe_flush = 1'b1;
        end

        stall_d = (pc_hold && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
        flush_d = (if2id_flush && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign state        = logic'(state_q);
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule
